// File: rtl/hazard_pkg.sv
// hazard_pkg: stall FSM encoding, forwarding selects and the forwarding-match helper
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MISS = 2'd1, RESUME = 2'd2} state_e;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] dst_m,
                                         input logic [4:0] dst_w, input logic wr_m, input logic wr_w);
    return (wr_m && dst_m != 5'd0 && dst_m == src) ? FWD_MEM :
           (wr_w && dst_w != 5'd0 && dst_w == src) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/sat_cnt32.sv
// sat_cnt32: 32-bit event counter with synchronous active-low clear that sticks at all-ones
module sat_cnt32 (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [31:0] cnt
);
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = !clr_n ? 32'd0 : (en && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forwarding control with a data-miss stall FSM
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  reg1_srcD,
  input  logic [4:0]  reg2_srcD,
  input  logic [4:0]  reg1_srcE,
  input  logic [4:0]  reg2_srcE,
  input  logic [4:0]  reg_dstE,
  input  logic [4:0]  reg_dstM,
  input  logic [4:0]  reg_dstW,
  input  logic        load_E,
  input  logic        reg_writeM,
  input  logic        reg_writeW,
  input  logic        br_takenE,
  input  logic        jalD,
  input  logic        dmissM,
  input  logic        ddoneM,
  output logic        bubbleF,
  output logic        bubbleD,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic [1:0]  op1_sel,
  output logic [1:0]  op2_sel,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  state_e state_q, state_d;
  logic   miss_stall, load_use;
  assign miss_stall = state_q == MISS || (state_q == RUN && dmissM);
  assign load_use   = load_E && reg_dstE != 5'd0 && (reg_dstE == reg1_srcD || reg_dstE == reg2_srcD);
  always_comb begin
    state_d = !rst_n ? RUN :
              state_q == RUN  ? (dmissM ? MISS : RUN) :
              state_q == MISS ? (ddoneM ? RESUME : MISS) : RUN;
    {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b00000;
    {flushF, flushD, flushE, flushM, flushW}      = 5'b00000;
    if (!rst_n)
      {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
    else if (miss_stall) begin
      {bubbleF, bubbleD, bubbleE, bubbleM} = 4'b1111;
      flushW = 1'b1;
    end else if (br_takenE)
      {flushD, flushE} = 2'b11;
    else if (load_use) begin
      {bubbleF, bubbleD} = 2'b11;
      flushE = 1'b1;
    end else if (jalD)
      flushD = 1'b1;
  end
  always_ff @(posedge clk) state_q <= state_d;
  assign op1_sel = rst_n ? fwd_sel(reg1_srcE, reg_dstM, reg_dstW, reg_writeM, reg_writeW) : FWD_REG;
  assign op2_sel = rst_n ? fwd_sel(reg2_srcE, reg_dstM, reg_dstW, reg_writeM, reg_writeW) : FWD_REG;
  sat_cnt32 u_stall (.clk(clk), .clr_n(rst_n), .en(bubbleF), .cnt(stall_cnt));
  sat_cnt32 u_flush (.clk(clk), .clr_n(rst_n), .en(flushD | flushE), .cnt(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random stimulus, expected responses queued and checked by a monitor
module tb_hazard_ctrl;
  typedef struct packed {
    logic rst_n;
    logic [4:0] s1d, s2d, s1e, s2e, de, dm, dw;
    logic lde, wm, ww, br, jal, dmiss, ddone;
  } stim_t;
  typedef struct packed {
    logic [4:0] bub, fl;
    logic [1:0] o1, o2;
    logic [31:0] sc, fc;
  } exp_t;
  logic clk = 0;
  logic rst_n;
  logic [4:0] reg1_srcD, reg2_srcD, reg1_srcE, reg2_srcE, reg_dstE, reg_dstM, reg_dstW;
  logic load_E, reg_writeM, reg_writeW, br_takenE, jalD, dmissM, ddoneM;
  logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic [1:0] op1_sel, op2_sel;
  logic [31:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  exp_t q[$];
  int m_state = 0;
  logic [31:0] m_sc = 0, m_fc = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .reg1_srcD(reg1_srcD), .reg2_srcD(reg2_srcD), .reg1_srcE(reg1_srcE), .reg2_srcE(reg2_srcE),
    .reg_dstE(reg_dstE), .reg_dstM(reg_dstM), .reg_dstW(reg_dstW),
    .load_E(load_E), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .br_takenE(br_takenE), .jalD(jalD), .dmissM(dmissM), .ddoneM(ddoneM),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction
  function automatic logic [1:0] fwd(logic [4:0] src, stim_t s);
    if (s.wm && s.dm != 0 && s.dm == src) return 2'b01;
    if (s.ww && s.dw != 0 && s.dw == src) return 2'b10;
    return 2'b00;
  endfunction
  // Reference: priority list miss > branch > load-use > jal; m_state 0=RUN 1=MISS 2=RESUME
  function automatic exp_t model(stim_t s);
    exp_t e = '0;
    bit hz;
    e.sc = m_sc;
    e.fc = m_fc;
    if (!s.rst_n) begin
      e.fl = 5'b11111;
      return e;
    end
    e.o1 = fwd(s.s1e, s);
    e.o2 = fwd(s.s2e, s);
    hz = s.lde && s.de != 0 && (s.de == s.s1d || s.de == s.s2d);
    if (m_state == 1 || (m_state == 0 && s.dmiss)) begin
      e.bub = 5'b11110;
      e.fl  = 5'b00001;
    end else if (s.br) e.fl = 5'b01100;
    else if (hz) begin
      e.bub = 5'b11000;
      e.fl  = 5'b00100;
    end else if (s.jal) e.fl = 5'b01000;
    return e;
  endfunction
  task automatic advance(stim_t s, exp_t e);
    if (!s.rst_n) begin
      m_state = 0; m_sc = 0; m_fc = 0;
      return;
    end
    if (e.bub[4] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if ((e.fl[3] || e.fl[2]) && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    case (m_state)
      0: m_state = s.dmiss ? 1 : 0;
      1: m_state = s.ddone ? 2 : 1;
      default: m_state = 0;
    endcase
  endtask
  task automatic apply(stim_t s);
    rst_n = s.rst_n; reg1_srcD = s.s1d; reg2_srcD = s.s2d; reg1_srcE = s.s1e; reg2_srcE = s.s2e;
    reg_dstE = s.de; reg_dstM = s.dm; reg_dstW = s.dw; load_E = s.lde; reg_writeM = s.wm;
    reg_writeW = s.ww; br_takenE = s.br; jalD = s.jal; dmissM = s.dmiss; ddoneM = s.ddone;
  endtask
  task automatic cyc(stim_t s);
    exp_t e;
    apply(s);
    e = model(s);
    q.push_back(e);
    advance(s, e);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("bubble", {27'd0, bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}, {27'd0, e.bub});
      chk("flush", {27'd0, flushF, flushD, flushE, flushM, flushW}, {27'd0, e.fl});
      chk("op1_sel", {30'd0, op1_sel}, {30'd0, e.o1});
      chk("op2_sel", {30'd0, op2_sel}, {30'd0, e.o2});
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    stim_t s;
    s = idle(); s.rst_n = 0;
    apply(s);
    @(posedge clk); #1;
    s.wm = 1; s.dm = 3; s.s1e = 3; s.ww = 1; s.dw = 4; s.s2e = 4;
    repeat (2) cyc(s);
    cyc(idle());
    s = idle(); s.lde = 1; s.de = 5; s.s1d = 5;
    cyc(s);
    s.s1d = 1; s.s2d = 5; s.jal = 1;
    cyc(s);
    cyc(idle());
    s = idle(); s.dmiss = 1;
    repeat (4) cyc(s);
    s = idle(); s.ddone = 1;
    cyc(s);
    s = idle(); s.dmiss = 1;
    cyc(s);
    cyc(idle());
    s = idle(); s.br = 1; s.lde = 1; s.de = 9; s.s2d = 9; s.jal = 1;
    cyc(s);
    s = idle(); s.jal = 1;
    cyc(s);
    s = idle(); s.wm = 1; s.ww = 1; s.dm = 7; s.dw = 7; s.s1e = 7; s.s2e = 7;
    cyc(s);
    s.dm = 0;
    cyc(s);
    s.wm = 0; s.dm = 7; s.s2e = 2;
    cyc(s);
    force dut.u_stall.cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_stall.cnt_q;
    m_sc = 32'hFFFF_FFFD;
    s = idle(); s.lde = 1; s.de = 12; s.s1d = 12;
    repeat (5) cyc(s);
    cyc(idle());
    s = idle(); s.dmiss = 1;
    repeat (2) cyc(s);
    s = idle(); s.rst_n = 0;
    cyc(s);
    cyc(idle());
    s = idle(); s.ddone = 1;
    cyc(s);
    s = idle(); s.dmiss = 1;
    cyc(s);
    s = idle(); s.ddone = 1;
    cyc(s);
    cyc(idle());
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = $urandom_range(0, 49) != 0;
      s.s1d = 5'($urandom_range(0, 3)); s.s2d = 5'($urandom_range(0, 3));
      s.s1e = 5'($urandom_range(0, 3)); s.s2e = 5'($urandom_range(0, 3));
      s.de = 5'($urandom_range(0, 3)); s.dm = 5'($urandom_range(0, 3)); s.dw = 5'($urandom_range(0, 3));
      s.lde = 1'($urandom_range(0, 1)); s.wm = 1'($urandom_range(0, 1)); s.ww = 1'($urandom_range(0, 1));
      s.br = $urandom_range(0, 5) == 0; s.jal = $urandom_range(0, 5) == 0;
      s.dmiss = $urandom_range(0, 7) == 0; s.ddone = $urandom_range(0, 3) == 0;
      cyc(s);
    end
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports, in this order:
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- reg1_srcD, reg2_srcD, in, 5 each: source register indices in ID.
- reg1_srcE, reg2_srcE, in, 5 each: source register indices in EX.
- reg_dstE, reg_dstM, reg_dstW, in, 5 each: destination register indices in EX, MEM and WB.
- load_E, in, 1: the EX instruction is a load.
- reg_writeM, reg_writeW, in, 1 each: write enables in MEM and WB.
- br_takenE, in, 1: a taken branch or jalr is resolved in EX.
- jalD, in, 1: a jal is decoded in ID.
- dmissM, in, 1: the data cache reports a miss for the MEM access.
- ddoneM, in, 1: the data cache refill is complete (one-cycle pulse).
- bubbleF/D/E/M/W, out, 1 each: hold the register of that stage.
- flushF/D/E/M/W, out, 1 each: clear the register of that stage.
- op1_sel, op2_sel, out, 2 each: forwarding select, 00 = register file, 01 = MEM, 10 = WB.
- stall_cnt, flush_cnt, out, 32 each: performance counters.

Function
REQ-002 The stall FSM SHALL have three states:
- RUN -> MISS when dmissM=1.
- MISS -> RESUME when ddoneM=1.
- RESUME -> RUN unconditionally.

REQ-003 In state MISS, or in RUN with dmissM=1, the block SHALL assert bubbleF, bubbleD, bubbleE, bubbleM and flushW, and deassert every other bubble and flush output.

REQ-004 In RESUME, dmissM SHALL be ignored for that cycle, which tolerates a stale miss level from the cache; the pipeline advances normally.

REQ-005 When no miss stall applies and br_takenE=1, the block SHALL assert flushD and flushE; this overrides load-use and jal.

REQ-006 Load-use hazard: load_E=1, reg_dstE!=0, and reg_dstE equals reg1_srcD or reg2_srcD. When this holds with no miss and no branch, the block SHALL assert bubbleF, bubbleD and flushE.

REQ-007 When jalD=1 with no miss, no branch and no load-use, the block SHALL assert flushD. When jalD and load-use coincide, flushD SHALL stay low, so the jal is held in ID.

REQ-008 op1_sel SHALL be computed combinationally with MEM priority over WB:
- 01 if reg_writeM=1, reg_dstM!=0 and reg_dstM=reg1_srcE;
- else 10 if reg_writeW=1, reg_dstW!=0 and reg_dstW=reg1_srcE;
- else 00.

REQ-009 op2_sel SHALL use the same rule as REQ-008 with reg2_srcE.

REQ-010 stall_cnt SHALL increment by 1 on every cycle in which bubbleF=1, and SHALL saturate at 0xFFFFFFFF with no wrap.

REQ-011 flush_cnt SHALL increment by 1 on every cycle in which flushD=1 or flushE=1, and SHALL saturate at 0xFFFFFFFF with no wrap.

REQ-012 All bubble and flush outputs SHALL be combinational functions of the current state and inputs, giving zero added latency. The FSM state and both counters SHALL be registered.

Reset
REQ-013 While rst_n=0 at a rising edge, the next state SHALL be RUN and both counters SHALL become 0.

REQ-014 While rst_n=0, flushF through flushW SHALL all be 1, all bubble outputs SHALL be 0, and op1_sel and op2_sel SHALL be 00.

REQ-015 A reset asserted in MISS or RESUME SHALL abandon the stall; a ddoneM arriving after reset SHALL be ignored in RUN.

Structure
REQ-016 A shared package hazard_pkg SHALL hold the FSM state encoding (RUN=0, MISS=1, RESUME=2) and the forwarding constants FWD_REG, FWD_MEM and FWD_WB.

REQ-017 A sub-module sat_cnt32 (enable input, synchronous active-low clear, saturating 32-bit counter) SHALL be instantiated twice.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Load in EX writes x5, ID reads x5 -> bubbleF=bubbleD=flushE=1 for 1 cycle; stall_cnt +1.
- dmissM=1 for 4 cycles, then ddoneM pulse -> MISS for 4 cycles with bubbleF/D/E/M=1 and flushW=1, then RESUME for 1 cycle, then RUN; stall_cnt +5.
- br_takenE=1 together with load-use -> only flushD and flushE=1; flush_cnt +1.
- reg_dstM=reg_dstW=x7, both writing, reg1_srcE=x7 -> op1_sel=01. Same case with reg_dstM=x0 -> op1_sel=10.
- stall_cnt preloaded near 0xFFFFFFFF, then 3 stall cycles -> holds at 0xFFFFFFFF.
- rst_n=0 during MISS -> all flush outputs=1 and counters=0; after release, ddoneM leaves the FSM in RUN.
